// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: single-outstanding load/store initiator and sole master of the data RAM port.
// Define STORE_VERIFY_EN to read back every store and flag a mismatch as an error.
module ram_access_ctrl #(
    parameter int ADDR_LIMIT = 8,
    parameter int READ_WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_error,
    output logic        write_enable,
    output logic        ram_read,
    output logic [15:0] access_address,
    output logic [15:0] write_data,
    input  logic [15:0] data_out
);

    // Widened by one bit so an ADDR_LIMIT of 65536 still compares correctly.
    localparam logic [16:0] LIMIT     = 17'(ADDR_LIMIT);
    localparam logic [3:0]  WAIT_LAST = 4'(READ_WAIT);

`ifdef STORE_VERIFY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, RD = 3'd1, WR = 3'd2, RESP = 3'd3, VRFY = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, RD = 3'd1, WR = 3'd2, RESP = 3'd3} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if ({1'b0, req_addr} >= LIMIT) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = req_write ? WR : RD;
                    end
                end
            end
            RD: begin
                if (cnt_q == WAIT_LAST) begin
                    rdata_d = data_out;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR: begin
`ifdef STORE_VERIFY_EN
                state_d = VRFY;
`else
                state_d = RESP;
`endif
            end
`ifdef STORE_VERIFY_EN
            VRFY: begin
                if (cnt_q == WAIT_LAST) begin
                    err_d   = (data_out != wdata_q);
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything below decodes from registered state only; req_* never reaches the RAM combinationally.
    always_comb begin
        req_ready      = (state_q == IDLE);
        resp_valid     = (state_q == RESP);
        resp_rdata     = (state_q == RESP) ? rdata_q : 16'h0000;
        resp_error     = (state_q == RESP) && err_q;
        write_enable   = (state_q == WR);
        write_data     = (state_q == WR) ? wdata_q : 16'h0000;
`ifdef STORE_VERIFY_EN
        ram_read       = (state_q == RD) || (state_q == VRFY);
`else
        ram_read       = (state_q == RD);
`endif
        access_address = (write_enable || ram_read) ? addr_q : 16'h0000;
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: three instances (READ_WAIT 0, 2, 3), each with its own RAM model.
// Request vectors come from a table; expected responses go through a queue scoreboard.
`timescale 1ns/1ps
module tb_ram_access_ctrl;

    localparam int N = 3;
`ifdef STORE_VERIFY_EN
    localparam int SV = 1;
`else
    localparam int SV = 0;
`endif

    typedef struct {
        int          k;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        corrupt;
        logic        exp_err;
        logic [15:0] exp_rdata;
        int          lat;
        int          we;
        int          rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst            [N];
    logic        req_valid      [N];
    logic        req_ready      [N];
    logic        req_write      [N];
    logic [15:0] req_addr       [N];
    logic [15:0] req_wdata      [N];
    logic        resp_valid     [N];
    logic [15:0] resp_rdata     [N];
    logic        resp_error     [N];
    logic        write_enable   [N];
    logic        ram_read       [N];
    logic [15:0] access_address [N];
    logic [15:0] write_data     [N];
    logic        corrupt        [N];

    logic [16:0] exp_q [$];
    int          lat_q [$];
    vec_t        vecs  [$];
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        logic [15:0] mem [8];
        logic [15:0] dout;

        // RAM model; corrupt forces the read port to zero to provoke a verify mismatch.
        assign dout = corrupt[k] ? 16'h0000 :
                      ((access_address[k] < 16'd8) ? mem[access_address[k][2:0]] : 16'h0000);

        always @(posedge clk) begin
            if (write_enable[k] && access_address[k] < 16'd8)
                mem[access_address[k][2:0]] <= write_data[k];
        end

        ram_access_ctrl #(
            .ADDR_LIMIT(8),
            .READ_WAIT((k == 0) ? 0 : ((k == 1) ? 2 : 3))
        ) u_dut (
            .clk           (clk),
            .reset         (rst[k]),
            .req_valid     (req_valid[k]),
            .req_ready     (req_ready[k]),
            .req_write     (req_write[k]),
            .req_addr      (req_addr[k]),
            .req_wdata     (req_wdata[k]),
            .resp_valid    (resp_valid[k]),
            .resp_rdata    (resp_rdata[k]),
            .resp_error    (resp_error[k]),
            .write_enable  (write_enable[k]),
            .ram_read      (ram_read[k]),
            .access_address(access_address[k]),
            .write_data    (write_data[k]),
            .data_out      (dout)
        );
    end

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic add(input int k, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic cor, input logic err, input logic [15:0] rdata,
                       input int lat, input int we, input int rd);
        vec_t v;
        v.k = k; v.wr = wr; v.addr = addr; v.wdata = wdata; v.corrupt = cor;
        v.exp_err = err; v.exp_rdata = rdata; v.lat = lat; v.we = we; v.rd = rd;
        vecs.push_back(v);
    endtask

    // Issue one request, then watch the bus cycle by cycle until the response pulse.
    task automatic do_req(input vec_t v);
        int          k;
        int          lat;
        int          we_n;
        int          rd_n;
        bit          got;
        bit          bad_bus;
        bit          dirty;
        logic [16:0] e;
        int          el;
        k = v.k; lat = 0; we_n = 0; rd_n = 0; got = 0; bad_bus = 0; dirty = 0;
        corrupt[k] = v.corrupt;
        @(negedge clk);
        check("ready_idle", k, req_ready[k], 1);
        req_valid[k] = 1'b1;
        req_write[k] = v.wr;
        req_addr[k]  = v.addr;
        req_wdata[k] = v.wdata;
        exp_q.push_back({v.exp_err, v.exp_rdata});
        lat_q.push_back(v.lat);
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (write_enable[k]) begin
                we_n++;
                if (access_address[k] != v.addr || write_data[k] != v.wdata) bad_bus = 1;
            end else if (write_data[k] != 16'h0) bad_bus = 1;
            if (ram_read[k]) begin
                rd_n++;
                if (access_address[k] != v.addr || write_enable[k]) bad_bus = 1;
            end
            if (!write_enable[k] && !ram_read[k] && access_address[k] != 16'h0) bad_bus = 1;
            if (req_ready[k]) bad_bus = 1;
            if (resp_valid[k]) begin
                got = 1;
                req_valid[k] = 1'b0;
                e  = exp_q.pop_front();
                el = lat_q.pop_front();
                check("resp_rdata", k, resp_rdata[k], e[15:0]);
                check("resp_error", k, resp_error[k], e[16]);
                check("latency", k, lat, el);
            end else begin
                if (resp_rdata[k] != 16'h0 || resp_error[k]) dirty = 1;
                // Noise on req_* while busy must be ignored.
                req_valid[k] = 1'($urandom_range(0, 1));
                req_write[k] = 1'($urandom_range(0, 1));
                req_addr[k]  = 16'($urandom_range(0, 15));
                req_wdata[k] = 16'($urandom);
            end
        end
        if (!got) begin
            check("resp_timeout", k, 0, 1);
            req_valid[k] = 1'b0;
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
        check("we_cycles", k, we_n, v.we);
        check("rd_cycles", k, rd_n, v.rd);
        check("bus_ok", k, bad_bus, 0);
        check("resp_quiet", k, dirty, 0);
        @(negedge clk);
        check("ready_after", k, {req_ready[k], resp_valid[k]}, 2'b10);
        corrupt[k] = 1'b0;
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; corrupt[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("reset_ready", k, req_ready[k], 1);
            check("reset_ram_side", k, {write_enable[k], ram_read[k], access_address[k], write_data[k]}, 0);
            check("reset_resp", k, {resp_valid[k], resp_rdata[k], resp_error[k]}, 0);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (resp_valid[k] || write_enable[k] || ram_read[k]) seen = 1;
        end
        check("idle_quiet", 0, seen, 0);

        //  k  wr    addr      wdata   cor  err  rdata    lat          we rd
        add(0, 1, 16'd3,    16'hA5C3, 0,  0,   16'h0,   2 + SV,      1, SV);
        add(0, 0, 16'd3,    16'h0,    0,  0,   16'hA5C3, 2,          0, 1);
        add(0, 0, 16'd8,    16'h0,    0,  1,   16'h0,   1,           0, 0);
        add(0, 1, 16'hFFFF, 16'h5555, 0,  1,   16'h0,   1,           0, 0);
        add(0, 1, 16'd7,    16'h7E57, 0,  0,   16'h0,   2 + SV,      1, SV);
        add(0, 0, 16'd7,    16'h0,    0,  0,   16'h7E57, 2,          0, 1);
        add(0, 1, 16'd2,    16'h1234, 1,  1'(SV), 16'h0, 2 + SV,     1, SV);
        add(0, 1, 16'd2,    16'h1234, 0,  0,   16'h0,   2 + SV,      1, SV);
        add(0, 0, 16'd2,    16'h0,    0,  0,   16'h1234, 2,          0, 1);
        add(1, 1, 16'd3,    16'hA5C3, 0,  0,   16'h0,   2 + 3 * SV,  1, 3 * SV);
        add(1, 0, 16'd3,    16'h0,    0,  0,   16'hA5C3, 4,          0, 3);
        add(1, 0, 16'd8,    16'h0,    0,  1,   16'h0,   1,           0, 0);
        add(1, 1, 16'd0,    16'hC0DE, 1,  1'(SV), 16'h0, 2 + 3 * SV, 1, 3 * SV);
        add(2, 1, 16'd5,    16'hBEEF, 0,  0,   16'h0,   2 + 4 * SV,  1, 4 * SV);
        foreach (vecs[i]) do_req(vecs[i]);

        // Reset in the middle of a READ_WAIT=3 load aborts it with no response.
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 16'd5;
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("abort_in_rd", 2, ram_read[2], 1);
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check("abort_outputs", 2, {resp_valid[2], write_enable[2], ram_read[2]}, 0);
        check("abort_ready", 2, req_ready[2], 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid[2]) seen = 1;
        end
        check("abort_no_resp", 2, seen, 0);
        vecs.delete();
        add(2, 1, 16'd0, 16'h0F0F, 0, 0, 16'h0,    2 + 4 * SV, 1, 4 * SV);
        add(2, 0, 16'd0, 16'h0,    0, 0, 16'h0F0F, 5,          0, 4);
        add(2, 0, 16'd5, 16'h0,    0, 0, 16'hBEEF, 5,          0, 4);
        foreach (vecs[i]) do_req(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
